seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parametrised successor of the fixed 3-bit "101" recogniser.
- Detects a runtime-programmable N-bit serial pattern on input x, one bit per enabled clock.
- Supports overlapping and non-overlapping match modes, and keeps a saturating match counter.
- Sits on a serial input line and feeds a status/interrupt collector.

Parameters:
- N, 3, pattern length in bits (2..16).
- PATTERN_RST, 3'b101, pattern loaded at reset (N bits, MSB = first bit received).
- CNT_W, 8, width of the match counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  bit-valid qualifier; x is sampled only when en=1.
- x  in  1  serial data bit.
- overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  N  new pattern, MSB first.
- cnt_clr  in  1  synchronous clear of match_cnt.
- z  out  1  one-cycle match pulse (registered, Moore-style).
- match_cnt  out  CNT_W  number of matches, saturating.
- cnt_sat  out  1  high while match_cnt is all-ones.

Behaviour:
- Reset (reset=0, asynchronous):
  - pat=PATTERN_RST; hist=0; fill=0.
  - z=0; match_cnt=0; cnt_sat=0.
- Internal state:
  - hist[N-1:0] is the shift history; newest bit is in hist[0].
  - fill is a 0..N counter of valid history bits; it saturates at N.
- Per rising edge, in priority order:
  1. pat_load=1:
     - pat<=pat_in; hist<=0; fill<=0; z<=0.
     - The x bit in this cycle is discarded, even when en=1.
     - match_cnt is unaffected, except by cnt_clr.
  2. en=1:
     - nh={hist[N-2:0],x}; nf=min(fill+1,N).
     - hit=(nf==N) && (nh==pat).
     - hist<=nh; z<=hit.
     - If hit and overlap=0: fill<=0. Otherwise fill<=nf.
  3. en=0: hist and fill hold; z<=0.
- Latency: if the last pattern bit is sampled at edge k, z=1 for exactly the cycle following edge k.
- Consecutive enabled hits in overlap mode give back-to-back z pulses. Example: pattern 11, x=1,1,1 gives z high after the 2nd and 3rd bits.
- match_cnt:
  - Increments by 1 on each hit.
  - Saturates at 2^CNT_W-1 and never wraps.
  - cnt_sat=(match_cnt==all-ones), registered together with match_cnt.
  - cnt_clr=1 sets match_cnt<=0. cnt_clr has priority over a simultaneous hit; that hit is not counted, but z still pulses.
- Changing overlap mid-stream takes effect at the next enabled edge. History is not altered by the change itself.
- Reset asserted mid-sequence: all progress is lost immediately; z drops asynchronously.
- A partial sequence interrupted by en=0 gaps is preserved. Gaps do not break a match.

Optional Feature:
- Macro: SEQDET_STICKY_EN.
- When defined:
  - Adds output port match_seen (1 bit).
  - Set on any hit; cleared only by reset or cnt_clr.
  - On the same-edge set/clear conflict, cnt_clr wins.
- When undefined: port absent; no sticky logic.

Test Plan:
- Reset defaults, N=3, overlap=1, en=1: x=1,0,1,0,1 -> z pulses after the 3rd and 5th bits; match_cnt=2.
- Non-overlap mode: overlap=0, x=1,0,1,0,1 -> single z after the 3rd bit; match_cnt=1. A further x=0,1 -> second z; match_cnt=2.
- en gaps: x=1 (en=1), en=0 for 4 cycles, x=0, x=1 (en=1) -> z=1 one cycle after the final bit; z=0 during all gap cycles.
- Reprogram: pat_load with pat_in=3'b111 mid-stream (after x=1,0), then x=1,1,1,1 -> z after the 3rd and 4th bits; no match on the stale 101 history.
- Saturation: CNT_W=2, 5 overlapping hits -> match_cnt=3, cnt_sat=1. cnt_clr coinciding with a hit -> match_cnt=0, z=1.
- Async reset mid-sequence after x=1,0: pulse reset low between edges -> outputs 0 immediately. Post-reset x=1 alone produces no z.

Source files
------------

// File: rtl/seq_detect_param.sv
// seq_detect_param: runtime-programmable N-bit serial pattern recogniser.
//
// Bits arrive on x, one per clock while en is high, first bit first. The
// pattern register holds the sequence to look for, MSB = first bit received.
// A match raises z for exactly one cycle after the edge that sampled the last
// pattern bit. Matches are counted in a saturating counter.
//
// Optional build macro SEQDET_STICKY_EN adds the match_seen output. It is a
// sticky flag that is set by any match and cleared by reset or cnt_clr.
//
// The reset input is asynchronous and active-low, even though it is named
// "reset".
module seq_detect_param #(
   parameter int             N           = 3,
   parameter logic [N-1:0]   PATTERN_RST = 3'b101,
   parameter int             CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             x,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [N-1:0]     pat_in,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_sat
`ifdef SEQDET_STICKY_EN
   ,
   output logic             match_seen
`endif
);

   // The fill counter has to be able to hold every value from 0 to N.
   localparam int FW = $clog2(N + 1);
   localparam logic [FW-1:0]    FILL_FULL = FW'(N);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [N-1:0]     pat_q,  pat_d;
   logic [N-1:0]     hist_q, hist_d;
   logic [FW-1:0]    fill_q, fill_d;
   logic             z_q,    z_d;
   logic [CNT_W-1:0] cnt_q,  cnt_d;
   logic             sat_q,  sat_d;

   logic [N-1:0]     shifted;
   logic [FW-1:0]    fillInc;
   logic             hit;

   // Form the candidate history and fill level for an enabled bit, and
   // decide whether that bit completes the pattern.
   always_comb begin
      shifted = {hist_q[N-2:0], x};
      fillInc = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
      hit     = 1'b0;
      if (!pat_load && en && (fillInc == FILL_FULL) && (shifted == pat_q)) begin
         hit = 1'b1;
      end
   end

   // Next state for the pattern, history and fill level. A pattern load
   // takes precedence and discards the current bit. In non-overlap mode a
   // match empties the history, so the next match needs N fresh bits.
   always_comb begin
      pat_d  = pat_q;
      hist_d = hist_q;
      fill_d = fill_q;
      z_d    = 1'b0;
      if (pat_load) begin
         pat_d  = pat_in;
         hist_d = '0;
         fill_d = '0;
      end else if (en) begin
         hist_d = shifted;
         z_d    = hit;
         if (hit && !overlap) begin
            fill_d = '0;
         end else begin
            fill_d = fillInc;
         end
      end
   end

   // Match counter. A clear overrides a simultaneous hit, so that hit is
   // lost from the count. The counter sticks at all-ones instead of
   // wrapping. The saturation flag is computed from the next value so that
   // it stays aligned with the counter register.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      sat_d = (cnt_d == CNT_MAX);
   end

   // State registers. Reset clears all progress immediately and restores
   // the power-up pattern.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q  <= PATTERN_RST;
         hist_q <= '0;
         fill_q <= '0;
         z_q    <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         z_q    <= z_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign z         = z_q;
   assign match_cnt = cnt_q;
   assign cnt_sat   = sat_q;

`ifdef SEQDET_STICKY_EN
   logic seen_q, seen_d;

   // Sticky match flag. A clear wins over a hit on the same edge.
   always_comb begin
      seen_d = seen_q;
      if (cnt_clr) begin
         seen_d = 1'b0;
      end else if (hit) begin
         seen_d = 1'b1;
      end
   end

   // Sticky flag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         seen_q <= 1'b0;
      end else begin
         seen_q <= seen_d;
      end
   end

   assign match_seen = seen_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param (N=3, CNT_W=2 so that saturation is reachable).
// The bench keeps a queue-based model of the received bits. On every falling
// edge it compares the DUT outputs with that model, and it also checks a
// few hand-computed literal values.
module tb_seq_detect_param;

   localparam int N     = 3;
   localparam int CNT_W = 2;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             en, x, overlap, pat_load, cnt_clr;
   logic [N-1:0]     pat_in;
   logic             z;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;
`ifdef SEQDET_STICKY_EN
   logic             match_seen;
`endif

   int errors = 0;
   int checks = 0;

   // Model state.
   bit           mBits[$];
   logic [N-1:0] mPat;
   logic         mZ;
   int           mCnt;
   logic         mSeen;
   bit           active = 0;

   seq_detect_param #(.N(N), .PATTERN_RST(3'b101), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .x         (x),
      .overlap   (overlap),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .cnt_clr   (cnt_clr),
      .z         (z),
      .match_cnt (match_cnt),
      .cnt_sat   (cnt_sat)
`ifdef SEQDET_STICKY_EN
      ,
      .match_seen(match_seen)
`endif
   );

   // Free-running clock.
   always #5 clk = ~clk;

   // Counts one comparison and reports it if it failed.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   // Puts the model into its power-up state.
   task automatic modelReset();
      mBits.delete();
      mPat  = 3'b101;
      mZ    = 1'b0;
      mCnt  = 0;
      mSeen = 1'b0;
   endtask

   // Applies the rules for one clock edge: keep the bits received since the
   // last flush, and report a match when the most recent N bits equal the
   // pattern.
   task automatic modelStep(input logic e, input logic xb, input logic ov,
                            input logic ld, input logic [N-1:0] pi, input logic clr);
      bit hitNow;
      hitNow = 0;
      if (ld) begin
         mPat = pi;
         mBits.delete();
         mZ = 1'b0;
      end else if (e) begin
         mBits.push_back(xb);
         if (mBits.size() > N) void'(mBits.pop_front());
         if (mBits.size() == N) begin
            hitNow = 1;
            for (int i = 0; i < N; i++)
               if (mBits[i] != mPat[N-1-i]) hitNow = 0;
         end
         mZ = hitNow;
         if (hitNow && !ov) mBits.delete();
      end else begin
         mZ = 1'b0;
      end
      if (clr) begin
         mCnt  = 0;
         mSeen = 1'b0;
      end else if (hitNow) begin
         if (mCnt < CMAX) mCnt++;
         mSeen = 1'b1;
      end
   endtask

   // Drives one cycle of inputs, advances the model at the rising edge and
   // returns at the following falling edge.
   task automatic applyStimulus(input logic e, input logic xb, input logic ov,
                                input logic ld, input logic [N-1:0] pi, input logic clr);
      en = e; x = xb; overlap = ov; pat_load = ld; pat_in = pi; cnt_clr = clr;
      @(posedge clk);
      modelStep(e, xb, ov, ld, pi, clr);
      @(negedge clk);
   endtask

   // Sends an enabled data bit with no pattern load and no counter clear.
   task automatic sendBit(input logic xb, input logic ov);
      applyStimulus(1'b1, xb, ov, 1'b0, 3'b000, 1'b0);
   endtask

   // Flushes the history by loading a pattern, and clears the counter.
   task automatic flush(input logic [N-1:0] pi, input logic ov);
      applyStimulus(1'b0, 1'b0, ov, 1'b1, pi, 1'b1);
   endtask

   // Pulses reset between clock edges and checks that the outputs drop at once.
   task automatic resetPulse(input string tag);
      #1 reset = 1'b0;
      #1;
      checkOutput({tag, "_z"},   z,         0);
      checkOutput({tag, "_cnt"}, match_cnt, 0);
      checkOutput({tag, "_sat"}, cnt_sat,   0);
      modelReset();
      #1 reset = 1'b1;
   endtask

   // Compares the DUT with the model on every falling edge.
   always @(negedge clk) begin
      if (active) begin
         checkOutput("z",         z,         mZ);
         checkOutput("match_cnt", match_cnt, mCnt);
         checkOutput("cnt_sat",   cnt_sat,   (mCnt == CMAX));
`ifdef SEQDET_STICKY_EN
         checkOutput("match_seen", match_seen, mSeen);
`endif
      end
   end

   // Directed scenarios.
   initial begin
      reset = 1'b0; en = 0; x = 0; overlap = 1; pat_load = 0; pat_in = '0; cnt_clr = 0;
      modelReset();
      #2;
      checkOutput("rst_z",   z,         0);
      checkOutput("rst_cnt", match_cnt, 0);
      checkOutput("rst_sat", cnt_sat,   0);
      @(negedge clk);
      #2 reset = 1'b1;
      active = 1;

      $display("[TB] overlapping 10101");
      sendBit(1, 1); sendBit(0, 1); sendBit(1, 1);
      checkOutput("ov_z3", z, 1);
      sendBit(0, 1); sendBit(1, 1);
      checkOutput("ov_z5", z, 1);
      checkOutput("ov_cnt", match_cnt, 2);

      $display("[TB] non-overlapping 1010101");
      flush(3'b101, 0);
      sendBit(1, 0); sendBit(0, 0); sendBit(1, 0);
      checkOutput("nov_z3", z, 1);
      sendBit(0, 0); sendBit(1, 0);
      checkOutput("nov_z5", z, 0);
      checkOutput("nov_cnt1", match_cnt, 1);
      sendBit(0, 0); sendBit(1, 0);
      checkOutput("nov_z7", z, 1);
      checkOutput("nov_cnt2", match_cnt, 2);

      $display("[TB] en gaps");
      flush(3'b101, 0);
      sendBit(1, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0);
         checkOutput("gap_z", z, 0);
      end
      sendBit(0, 0); sendBit(1, 0);
      checkOutput("gap_hit", z, 1);

      $display("[TB] reprogram to 111");
      flush(3'b101, 1);
      sendBit(1, 1); sendBit(0, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0);
      checkOutput("load_z", z, 0);
      sendBit(1, 1); sendBit(1, 1);
      checkOutput("re_z2", z, 0);
      sendBit(1, 1);
      checkOutput("re_z3", z, 1);
      sendBit(1, 1);
      checkOutput("re_z4", z, 1);
      checkOutput("re_cnt", match_cnt, 2);

      $display("[TB] saturation");
      sendBit(1, 1); sendBit(1, 1);
      checkOutput("sat_cnt", match_cnt, 3);
      checkOutput("sat_flag", cnt_sat, 1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 1'b1);
      checkOutput("clrhit_z", z, 1);
      checkOutput("clrhit_cnt", match_cnt, 0);

      $display("[TB] async reset");
      resetPulse("rstz");
      sendBit(1, 1); sendBit(0, 1);
      resetPulse("rstmid");
      sendBit(1, 1);
      checkOutput("post_rst_z", z, 0);
      sendBit(0, 1); sendBit(1, 1);
      checkOutput("post_rst_hit", z, 1);

      active = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
